mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two masters share one memory slave with bounded ownership
// (at most HOLD back-to-back grants while the other master waits).
module mem_arbiter #(
  parameter int unsigned HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_byteen,
  output logic        s_re,
  input  logic [31:0] s_rdata,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(HOLD - 1);

  state_t     state;
  state_t     state_nx;
  logic       last;
  logic       last_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic       rd_pend;
  logic       rd_pend_nx;
  logic       rd_id;
  logic       rd_id_nx;

  logic       cur_id;
  logic       cur_req;
  logic       cur_we;
  logic       oth_req;
  state_t     oth_st;

  // cur_* is only meaningful while a master owns the slave
  assign cur_id  = (state == OWN1);
  assign cur_req = cur_id ? m1_req : m0_req;
  assign cur_we  = cur_id ? m1_we  : m0_we;
  assign oth_req = cur_id ? m0_req : m1_req;
  assign oth_st  = cur_id ? OWN0   : OWN1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      cnt     <= '0;
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      cnt     <= cnt_nx;
      rd_pend <= rd_pend_nx;
      rd_id   <= rd_id_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    last_nx    = last;
    cnt_nx     = cnt;
    rd_pend_nx = 1'b0;
    rd_id_nx   = rd_id;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (m0_req && (!m1_req || last)) begin
          state_nx = OWN0;
        end else if (m1_req) begin
          state_nx = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!cur_req) begin
          state_nx = oth_req ? oth_st : IDLE;
          last_nx  = cur_id;
          cnt_nx   = '0;
        end else begin
          if (!cur_we) begin
            rd_pend_nx = 1'b1;
            rd_id_nx   = cur_id;
          end
          // quota used up: yield only if the other side waits,
          // otherwise keep the count parked at its limit
          if (cnt >= CNT_MAX) begin
            if (oth_req) begin
              state_nx = oth_st;
              last_nx  = cur_id;
              cnt_nx   = '0;
            end
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_byteen = '0;
    s_re     = 1'b0;
    unique case (1'b1)
      (state == OWN0): begin
        m0_gnt   = m0_req;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_byteen = m0_we ? m0_byteen : 4'b0;
        s_re     = m0_req & ~m0_we;
      end
      (state == OWN1): begin
        m1_gnt   = m1_req;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_byteen = m1_we ? m1_byteen : 4'b0;
        s_re     = m1_req & ~m1_we;
      end
      default: begin
        m0_gnt = 1'b0;
      end
    endcase
  end

  // read data follows the accepted read, not the current owner
  assign m0_rvalid = rd_pend & ~rd_id;
  assign m1_rvalid = rd_pend &  rd_id;
  assign m0_rdata  = m0_rvalid ? s_rdata : 32'h0;
  assign m1_rdata  = m1_rvalid ? s_rdata : 32'h0;

  assign owner = state;

endmodule
